// File: rtl/analog_clock_core_if.sv
// analog_clock_core_if: control inputs and timekeeper/display outputs of the
// analog clock core. The master side drives the set-time controls; the slave
// side is the clock core itself.
interface analog_clock_core_if #(
  parameter int DIGITS = 4
);
  logic              mode24;
  logic              setMode;
  logic              incHour;
  logic              incMinute;
  logic [7:0]        hoursBcd;
  logic [7:0]        minutesBcd;
  logic [7:0]        secondsBcd;
  logic              secondPulse;
  logic [DIGITS-1:0] sevenSegmentEnable;
  logic [7:0]        sevenSegmentData;

  modport master (
    output mode24, setMode, incHour, incMinute,
    input  hoursBcd, minutesBcd, secondsBcd, secondPulse,
    input  sevenSegmentEnable, sevenSegmentData
  );

  modport slave (
    input  mode24, setMode, incHour, incMinute,
    output hoursBcd, minutesBcd, secondsBcd, secondPulse,
    output sevenSegmentEnable, sevenSegmentData
  );
endinterface

// File: rtl/analog_clock_core.sv
// analog_clock_core: single-clock HH:MM:SS BCD timekeeper with set-time
// controls, 12/24-hour display mapping and a multiplexed 4- or 6-digit
// active-low seven-segment driver. Storage is always 24-hour BCD.
// Optional feature macro: COLON_BLINK_EN (dp on the hour-units digit, and
// the minute-units digit in 6-digit builds, lit for the first half of each
// second and continuously in set mode). Default build leaves dp off.
module analog_clock_core #(
  parameter int CLK_HZ  = 100000000,
  parameter int SCAN_HZ = 1000,
  parameter int DIGITS  = 4
) (
  input logic               cmosClock,
  input logic               resetN,
  analog_clock_core_if.slave bus
);

  localparam int PW       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int SCAN_RAW = CLK_HZ / (SCAN_HZ * DIGITS);
  localparam int SCAN_DIV = (SCAN_RAW < 1) ? 1 : SCAN_RAW;
  localparam int SW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW       = $clog2(DIGITS);

  localparam logic [PW-1:0] PRE_TC  = PW'(CLK_HZ - 1);
  localparam logic [SW-1:0] SCAN_TC = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_TC  = IW'(DIGITS - 1);
  // Digit position offset: 4-digit builds skip the two seconds digits.
  localparam logic [2:0]    POS_OFS = (DIGITS == 6) ? 3'd0 : 3'd2;
`ifdef COLON_BLINK_EN
  localparam logic [PW-1:0] HALF    = PW'(CLK_HZ / 2);
`endif

  // BCD increment with wrap at 'top' (59 for minutes/seconds, 23 for hours).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
    if (v == top)
      bcd_inc = 8'h00;
    else if (v[3:0] == 4'd9)
      bcd_inc = {v[7:4] + 4'd1, 4'd0};
    else
      bcd_inc = {v[7:4], v[3:0] + 4'd1};
  endfunction

  // 24-hour BCD to 12-hour BCD: 00 -> 12, 13..23 -> 01..11.
  function automatic logic [7:0] hour12(input logic [7:0] h);
    if (h == 8'h00)
      hour12 = 8'h12;
    else if (h <= 8'h12)
      hour12 = h;
    else if (h[3:0] >= 4'd2)
      hour12 = {h[7:4] - 4'd1, h[3:0] - 4'd2};
    else
      hour12 = {h[7:4] - 4'd2, h[3:0] + 4'd8};
  endfunction

  // Active-low segment code, dp off.
  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'hC0;
      4'd1:    seg7 = 8'hF9;
      4'd2:    seg7 = 8'hA4;
      4'd3:    seg7 = 8'hB0;
      4'd4:    seg7 = 8'h99;
      4'd5:    seg7 = 8'h92;
      4'd6:    seg7 = 8'h82;
      4'd7:    seg7 = 8'hF8;
      4'd8:    seg7 = 8'h80;
      4'd9:    seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction

  logic [PW-1:0]     presc;
  logic [7:0]        sec_r, min_r, hr_r;
  logic              pulse_r;
  logic              inc_h_d, inc_m_d;
  logic [SW-1:0]     scan_cnt;
  logic [IW-1:0]     idx;
  logic              load;
  logic [DIGITS-1:0] en_r;
  logic [7:0]        seg_r;

  logic              tick;
  logic              rise_h, rise_m;
  logic [7:0]        disp_hr;
  logic [2:0]        pos;
  logic [3:0]        nib;
  logic              blank;
  logic [7:0]        seg_next;
  logic [DIGITS-1:0] en_next;

  assign tick   = !bus.setMode && (presc == PRE_TC);
  assign rise_h = bus.incHour && !inc_h_d;
  assign rise_m = bus.incMinute && !inc_m_d;

  // One-second prescaler; parked at zero while the time is being set.
  always_ff @(posedge cmosClock or negedge resetN) begin
    if (!resetN)
      presc <= '0;
    else if (bus.setMode || presc == PRE_TC)
      presc <= '0;
    else
      presc <= presc + PW'(1);
  end

  // Timekeeper: normal ticking with carries, or set-mode increments.
  always_ff @(posedge cmosClock or negedge resetN) begin
    if (!resetN) begin
      sec_r   <= 8'h00;
      min_r   <= 8'h00;
      hr_r    <= 8'h00;
      pulse_r <= 1'b0;
      inc_h_d <= 1'b0;
      inc_m_d <= 1'b0;
    end else begin
      inc_h_d <= bus.incHour;
      inc_m_d <= bus.incMinute;
      pulse_r <= tick;
      if (bus.setMode) begin
        sec_r <= 8'h00;
        if (rise_m) min_r <= bcd_inc(min_r, 8'h59);
        if (rise_h) hr_r  <= bcd_inc(hr_r, 8'h23);
      end else if (tick) begin
        sec_r <= bcd_inc(sec_r, 8'h59);
        if (sec_r == 8'h59) begin
          min_r <= bcd_inc(min_r, 8'h59);
          if (min_r == 8'h59) hr_r <= bcd_inc(hr_r, 8'h23);
        end
      end
    end
  end

  // Scan divider and digit index; 'load' refreshes the outputs one cycle
  // after each index change.
  always_ff @(posedge cmosClock or negedge resetN) begin
    if (!resetN) begin
      scan_cnt <= '0;
      idx      <= '0;
      load     <= 1'b0;
    end else begin
      load <= (scan_cnt == SCAN_TC);
      if (scan_cnt == SCAN_TC) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_TC) ? '0 : idx + IW'(1);
      end else begin
        scan_cnt <= scan_cnt + SW'(1);
      end
    end
  end

  // Digit selection, hour mapping, blanking and segment encoding.
  always_comb begin
    disp_hr = bus.mode24 ? hr_r : hour12(hr_r);
    pos     = 3'(idx) + POS_OFS;
    nib     = 4'd0;
    blank   = 1'b0;
    case (pos)
      3'd0: nib = sec_r[3:0];
      3'd1: nib = sec_r[7:4];
      3'd2: nib = min_r[3:0];
      3'd3: nib = min_r[7:4];
      3'd4: nib = disp_hr[3:0];
      3'd5: begin
        nib   = disp_hr[7:4];
        blank = !bus.mode24 && (disp_hr[7:4] == 4'd0);
      end
      default: nib = 4'd0;
    endcase
    seg_next = blank ? 8'hFF : seg7(nib);
`ifdef COLON_BLINK_EN
    if (pos == 3'd4 || (DIGITS == 6 && pos == 3'd2))
      seg_next[7] = !(bus.setMode || presc < HALF);
`endif
    en_next      = '1;
    en_next[idx] = 1'b0;
  end

  // Registered digit enable and segment data, updated together.
  always_ff @(posedge cmosClock or negedge resetN) begin
    if (!resetN) begin
      en_r  <= '1;
      seg_r <= 8'hFF;
    end else if (load) begin
      en_r  <= en_next;
      seg_r <= seg_next;
    end
  end

  assign bus.hoursBcd           = hr_r;
  assign bus.minutesBcd         = min_r;
  assign bus.secondsBcd         = sec_r;
  assign bus.secondPulse        = pulse_r;
  assign bus.sevenSegmentEnable = en_r;
  assign bus.sevenSegmentData   = seg_r;

endmodule

// File: tb/tb_analog_clock_core.sv
// tb_analog_clock_core: directed bench for analog_clock_core with
// CLK_HZ=100, SCAN_HZ=5, DIGITS=4 (scan step every 5 cycles).
`timescale 1ns/1ps
module tb_analog_clock_core;
  localparam int CLK_HZ  = 100;
  localparam int SCAN_HZ = 5;
  localparam int DIGITS  = 4;
`ifdef COLON_BLINK_EN
  localparam logic [31:0] HU_MASK = 32'h7F;
`else
  localparam logic [31:0] HU_MASK = 32'hFF;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   pulses   = 0;

  analog_clock_core_if #(.DIGITS(DIGITS)) bus();

  analog_clock_core #(
    .CLK_HZ (CLK_HZ),
    .SCAN_HZ(SCAN_HZ),
    .DIGITS (DIGITS)
  ) dut (
    .cmosClock(clk),
    .resetN   (rst_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one cycle; sampling happens on the falling edge.
  task automatic tick();
    @(negedge clk);
    if (bus.secondPulse) pulses++;
  endtask

  task automatic inc(input logic h, input logic m);
    bus.incHour   = h;
    bus.incMinute = m;
    tick();
    bus.incHour   = 1'b0;
    bus.incMinute = 1'b0;
    tick();
  endtask

  task automatic check_time(input string tag, input logic [23:0] exp);
    check(tag, {8'h00, bus.hoursBcd, bus.minutesBcd, bus.secondsBcd}, {8'h00, exp});
  endtask

  task automatic wait_en(input string tag, input logic [3:0] target);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (bus.sevenSegmentEnable == target) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  task automatic scan_chk(input string tag, input logic [3:0] en, input logic [31:0] data);
    check({tag, "_en"}, 32'(bus.sevenSegmentEnable), 32'(en));
    check({tag, "_data"}, 32'(bus.sevenSegmentData), data);
  endtask

  task automatic first_pulse(input string tag);
    int cyc;
    for (cyc = 1; cyc <= 200; cyc++) begin
      tick();
      if (bus.secondPulse) break;
    end
    check(tag, 32'(cyc), 32'd100);
  endtask

  initial begin
    int p;
    int first;
    int base;
    logic [23:0] t60;

    bus.mode24    = 1'b1;
    bus.setMode   = 1'b0;
    bus.incHour   = 1'b0;
    bus.incMinute = 1'b0;

    // Power-on reset state
    repeat (3) tick();
    check("rst_en", 32'(bus.sevenSegmentEnable), 32'hF);
    check("rst_data", 32'(bus.sevenSegmentData), 32'hFF);
    check_time("rst_time", 24'h000000);
    check("rst_pulse", 32'(bus.secondPulse), 32'd0);

    // First second after release, then asynchronous reset at cycle 137
    rst_n = 1'b1;
    first_pulse("first_pulse");
    check_time("time_1s", 24'h000001);
    repeat (37) tick();
    check("onehot_en", 32'($countones(~bus.sevenSegmentEnable)), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_en", 32'(bus.sevenSegmentEnable), 32'hF);
    check("async_data", 32'(bus.sevenSegmentData), 32'hFF);
    check_time("async_time", 24'h000000);
    tick();
    rst_n = 1'b1;
    first_pulse("pulse_after_rst");

    // Set mode: seconds clear, minute increments, held level counts once
    bus.setMode = 1'b1;
    tick();
    check_time("set_sec_clr", 24'h000000);
    base = pulses;
    repeat (5)  inc(1'b1, 1'b0);
    repeat (58) inc(1'b0, 1'b1);
    check_time("set_0558", 24'h055800);
    inc(1'b0, 1'b1);
    inc(1'b0, 1'b1);
    bus.incMinute = 1'b1;
    repeat (50) tick();
    bus.incMinute = 1'b0;
    tick();
    check_time("set_held", 24'h050100);
    check("no_pulse_set", 32'(pulses - base), 32'd0);

    // Simultaneous hour and minute edges from 23:59
    repeat (18) inc(1'b1, 1'b1);
    repeat (40) inc(1'b0, 1'b1);
    check_time("set_2359", 24'h235900);
    bus.incHour   = 1'b1;
    bus.incMinute = 1'b1;
    tick();
    check_time("simul_wrap", 24'h000000);
    bus.incHour   = 1'b0;
    bus.incMinute = 1'b0;
    tick();

    // Rollover 23:59:00 -> 00:00:00 over 60 seconds
    repeat (23) inc(1'b1, 1'b1);
    repeat (36) inc(1'b0, 1'b1);
    check_time("set_2359b", 24'h235900);
    bus.setMode = 1'b0;
    p = 0;
    first = 0;
    t60 = 24'hFFFFFF;
    for (int i = 1; i <= 6000; i++) begin
      tick();
      if (bus.secondPulse) begin
        p++;
        if (p == 1)  first = i;
        if (p == 60) t60 = {bus.hoursBcd, bus.minutesBcd, bus.secondsBcd};
      end
    end
    check("first_after_set", 32'(first), 32'd100);
    check("pulse_count", 32'(p), 32'd60);
    check("rollover_time", 32'(t60), 32'h000000);

    // Increment inputs have no effect outside set mode
    bus.incHour   = 1'b1;
    bus.incMinute = 1'b1;
    repeat (3) tick();
    bus.incHour   = 1'b0;
    bus.incMinute = 1'b0;
    tick();
    check("inc_ignored", 32'({bus.hoursBcd, bus.minutesBcd}), 32'h0000);

    // Scan in 12-hour mode at 13:05
    bus.setMode = 1'b1;
    tick();
    repeat (5) inc(1'b1, 1'b1);
    repeat (8) inc(1'b1, 1'b0);
    check_time("set_1305", 24'h130500);
    bus.mode24 = 1'b0;
    repeat (25) tick();
    wait_en("sync12", 4'b1110);
    scan_chk("d0_12h", 4'b1110, 32'h92);
    repeat (5) tick();
    scan_chk("d1_12h", 4'b1101, 32'hC0);
    repeat (5) tick();
    scan_chk("d2_12h", 4'b1011, 32'hF9 & HU_MASK);
    repeat (5) tick();
    scan_chk("d3_12h", 4'b0111, 32'hFF);

    // Same time in 24-hour mode
    bus.mode24 = 1'b1;
    repeat (25) tick();
    wait_en("sync24", 4'b1011);
    scan_chk("d2_24h", 4'b1011, 32'hB0 & HU_MASK);
    repeat (5) tick();
    scan_chk("d3_24h", 4'b0111, 32'hF9);

    // Stored 00 shows as 12 in 12-hour mode
    repeat (11) inc(1'b1, 1'b0);
    check_time("set_0005", 24'h000500);
    bus.mode24 = 1'b0;
    repeat (25) tick();
    wait_en("sync00", 4'b1011);
    scan_chk("d2_00h", 4'b1011, 32'hA4 & HU_MASK);
    repeat (5) tick();
    scan_chk("d3_00h", 4'b0111, 32'hF9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
